issue_queue: RTL and testbench

In-order instruction buffer between decode and the reservation station. It accepts decoded instructions through a valid/ready handshake and stores them in a DEPTH-entry FIFO. It presents one instruction at a time on a registered issue port that wires directly to the RS inputs (`unit`, `reg1`–`reg3`, `hasimm`, `imm`, `enable`). It holds the head instruction whenever the RS reports the target unit busy.

---
 rtl/issue_queue.sv | 152 +++++++++++++++
 tb/tb_issue_queue.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue.sv
// issue_queue: in-order decode -> reservation-station buffer.
// DEPTH-entry FIFO feeding a registered issue port. The head instruction is
// held while the reservation station reports its target unit busy.
// Optional feature: define ISSUE_BYPASS_EN to let a push into an empty queue
// with a free issue register load the issue register directly (1-cycle latency).

`ifndef REG_SIZE
`define REG_SIZE 5
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module issue_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  in_unit,
  input  logic [`REG_SIZE-1:0]        in_reg1,
  input  logic [`REG_SIZE-1:0]        in_reg2,
  input  logic [`REG_SIZE-1:0]        in_reg3,
  input  logic                        in_hasimm,
  input  logic signed [`WORD_SIZE-1:0] in_imm,
  input  logic [4:0]                  rs_busy,
  output logic [2:0]                  unit,
  output logic [`REG_SIZE-1:0]        reg1,
  output logic [`REG_SIZE-1:0]        reg2,
  output logic [`REG_SIZE-1:0]        reg3,
  output logic                        hasimm,
  output logic signed [`WORD_SIZE-1:0] imm,
  output logic                        enable,
  output logic                        illegal,
  output logic [CNT_W-1:0]            count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = 3 + 3 * `REG_SIZE + 1 + `WORD_SIZE;

  // FIFO storage; the issue register acts as the registered read stage
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [CNT_W-1:0]   count_next;
  logic [ENTRY_W-1:0] issue_reg;
  logic               enable_reg;
  logic               illegal_reg;

  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic [7:0]         busy_ext;
  logic               push;
  logic               legal;
  logic               fire;
  logic               slot_free;
  logic               pop;
  logic               bypass;
  logic               store;

  assign in_entry   = {in_unit, in_reg1, in_reg2, in_reg3, in_hasimm, in_imm};
  assign head_entry = mem[rd_ptr_reg];

  // Unit codes above 4 never reach the issue register, so the padded bits are unused
  assign busy_ext = {3'b000, rs_busy};

  assign in_ready  = (count_reg < CNT_W'(DEPTH));
  assign push      = in_valid && in_ready;
  assign legal     = (in_unit <= 3'd4);
  assign fire      = enable_reg && !busy_ext[unit];
  assign slot_free = !enable_reg || fire;
  assign pop       = slot_free && (count_reg != '0);

`ifdef ISSUE_BYPASS_EN
  // Only possible with an empty FIFO, so ordering is preserved
  assign bypass = push && legal && (count_reg == '0) && slot_free;
`else
  assign bypass = 1'b0;
`endif

  // Illegal pushes are consumed without being stored
  assign store = push && legal && !bypass;

  assign {unit, reg1, reg2, reg3, hasimm, imm} = issue_reg;
  assign enable  = enable_reg;
  assign illegal = illegal_reg;
  assign count   = count_reg;

  // Occupancy: a simultaneous store and pop leaves the count unchanged
  always_comb begin
    count_next = count_reg;
    case ({store, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // FIFO write port (no reset: contents are discarded via the pointers)
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr_reg] <= in_entry;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (store) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_next;
    end
  end

  // Issue register: load FIFO head or bypassed push, otherwise drop enable once free
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_reg  <= '0;
      enable_reg <= 1'b0;
    end else if (pop) begin
      issue_reg  <= head_entry;
      enable_reg <= 1'b1;
    end else if (bypass) begin
      issue_reg  <= in_entry;
      enable_reg <= 1'b1;
    end else if (slot_free) begin
      enable_reg <= 1'b0;
    end
  end

  // One-cycle pulse for each accepted illegal unit code
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_reg <= 1'b0;
    end else begin
      illegal_reg <= push && !legal;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed testbench for issue_queue. Latency expectations follow
// ISSUE_BYPASS_EN when it is defined for the build.

`ifndef REG_SIZE
`define REG_SIZE 5
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module tb_issue_queue;

  localparam int DEPTH   = 8;
  localparam int CNT_W   = 4;
  localparam int RS      = `REG_SIZE;
  localparam int WS      = `WORD_SIZE;
  localparam int ENTRY_W = 3 + 3 * RS + 1 + WS;
`ifdef ISSUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef logic [ENTRY_W-1:0] rec_t;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_unit;
  logic [RS-1:0]        in_reg1, in_reg2, in_reg3;
  logic                 in_hasimm;
  logic signed [WS-1:0] in_imm;
  logic [4:0]           rs_busy;
  logic [2:0]           unit;
  logic [RS-1:0]        reg1, reg2, reg3;
  logic                 hasimm;
  logic signed [WS-1:0] imm;
  logic                 enable;
  logic                 illegal;
  logic [CNT_W-1:0]     count;
  logic [7:0]           busy8;

  rec_t issued[$];
  int   n_cmp = 0;
  int   n_err = 0;

  issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_unit(in_unit), .in_reg1(in_reg1), .in_reg2(in_reg2), .in_reg3(in_reg3),
    .in_hasimm(in_hasimm), .in_imm(in_imm),
    .rs_busy(rs_busy),
    .unit(unit), .reg1(reg1), .reg2(reg2), .reg3(reg3),
    .hasimm(hasimm), .imm(imm), .enable(enable), .illegal(illegal),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign busy8 = {3'b000, rs_busy};

  // Record every instruction the RS will capture at the coming edge
  always @(negedge clk) begin
    if (!rst && enable && !busy8[unit]) begin
      issued.push_back({unit, reg1, reg2, reg3, hasimm, imm});
      $display("issue: unit=%0d r1=%0d r2=%0d r3=%0d hasimm=%0b imm=%h",
               unit, reg1, reg2, reg3, hasimm, imm);
    end
  end

  function automatic rec_t mk(input int i);
    return {3'(i % 5), RS'(i), RS'(i + 1), RS'(i + 2), 1'(i % 2), WS'(i * 100 - 50)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rec(input rec_t r);
    {in_unit, in_reg1, in_reg2, in_reg3, in_hasimm, in_imm} = r;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; rs_busy = '0;
    drive_rec('0); in_valid = 1'b0;
    step(); step();
    rst = 1'b0;
    n_cmp++; if (enable !== 1'b0) begin n_err++; $display("FAIL reset_enable: got %b want 0", enable); end
    n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    n_cmp++; if (count !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if ({unit, reg1, reg2, reg3, hasimm, imm} !== rec_t'(0)) begin
      n_err++; $display("FAIL reset_fields: got %h want 0", {unit, reg1, reg2, reg3, hasimm, imm});
    end
  endtask

  task automatic test_single();
    rec_t add_r;
    add_r = {3'b010, RS'(1), RS'(2), RS'(3), 1'b0, WS'(0)};
    issued.delete();
    rs_busy = '0;
    drive_rec(add_r);
    step();
    in_valid = 1'b0;
    repeat (LAT - 1) step();
    n_cmp++; if (enable !== 1'b1) begin n_err++; $display("FAIL single_enable: got %b want 1", enable); end
    n_cmp++; if ({unit, reg1, reg2, reg3, hasimm, imm} !== add_r) begin
      n_err++; $display("FAIL single_fields: got %h want %h", {unit, reg1, reg2, reg3, hasimm, imm}, add_r);
    end
    step();
    n_cmp++; if (enable !== 1'b0) begin n_err++; $display("FAIL single_enable_fall: got %b want 0", enable); end
    n_cmp++; if (issued.size() !== 1) begin n_err++; $display("FAIL single_issue_count: got %0d want 1", issued.size()); end
  endtask

  task automatic test_fill();
    int   n_acc;
    rec_t got;
    n_acc = 0;
    issued.delete();
    rs_busy = 5'b11111;
    for (int i = 0; i < 10; i++) begin
      drive_rec(mk(i));
      if (in_ready) n_acc++;
      step();
    end
    in_valid = 1'b0;
    n_cmp++; if (n_acc !== 9) begin n_err++; $display("FAIL fill_accepts: got %0d want 9", n_acc); end
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL fill_count: got %0d want 8", count); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (enable !== 1'b1) begin n_err++; $display("FAIL fill_enable: got %b want 1", enable); end
    n_cmp++; if ({unit, reg1, reg2, reg3, hasimm, imm} !== mk(0)) begin
      n_err++; $display("FAIL fill_head: got %h want %h", {unit, reg1, reg2, reg3, hasimm, imm}, mk(0));
    end
    n_cmp++; if (issued.size() !== 0) begin n_err++; $display("FAIL fill_no_issue: got %0d want 0", issued.size()); end
    rs_busy = '0;
    repeat (9) step();
    n_cmp++; if (issued.size() !== 9) begin n_err++; $display("FAIL fill_drain_count: got %0d want 9", issued.size()); end
    for (int k = 0; k < 9; k++) begin
      got = (k < issued.size()) ? issued[k] : 'x;
      n_cmp++; if (got !== mk(k)) begin n_err++; $display("FAIL fill_order[%0d]: got %h want %h", k, got, mk(k)); end
    end
    n_cmp++; if (enable !== 1'b0) begin n_err++; $display("FAIL fill_end_enable: got %b want 0", enable); end
    n_cmp++; if (count !== '0) begin n_err++; $display("FAIL fill_end_count: got %0d want 0", count); end
  endtask

  task automatic test_stall();
    rec_t mul_r, add_r, got;
    mul_r = {3'b011, RS'(4), RS'(5), RS'(6), 1'b0, WS'(0)};
    add_r = {3'b010, RS'(7), RS'(8), RS'(9), 1'b1, WS'(77)};
    issued.delete();
    rs_busy = 5'b01000;
    drive_rec(mul_r); step();
    drive_rec(add_r); step();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if ({unit, reg1, reg2, reg3, hasimm, imm} !== mul_r || enable !== 1'b1) begin
        n_err++; $display("FAIL stall_hold[%0d]: got en=%b %h want en=1 %h", c, enable,
                          {unit, reg1, reg2, reg3, hasimm, imm}, mul_r);
      end
      n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL stall_count[%0d]: got %0d want 1", c, count); end
      step();
    end
    n_cmp++; if (issued.size() !== 0) begin n_err++; $display("FAIL stall_no_issue: got %0d want 0", issued.size()); end
    rs_busy = '0;
    step();
    n_cmp++; if ({unit, reg1, reg2, reg3, hasimm, imm} !== add_r || enable !== 1'b1) begin
      n_err++; $display("FAIL stall_next: got en=%b %h want en=1 %h", enable, {unit, reg1, reg2, reg3, hasimm, imm}, add_r);
    end
    step();
    n_cmp++; if (enable !== 1'b0) begin n_err++; $display("FAIL stall_end_enable: got %b want 0", enable); end
    got = (issued.size() > 0) ? issued[0] : 'x;
    n_cmp++; if (got !== mul_r) begin n_err++; $display("FAIL stall_first: got %h want %h", got, mul_r); end
    got = (issued.size() > 1) ? issued[1] : 'x;
    n_cmp++; if (got !== add_r) begin n_err++; $display("FAIL stall_second: got %h want %h", got, add_r); end
  endtask

  task automatic test_back_to_back();
    rec_t got;
    issued.delete();
    rs_busy = 5'b11111;
    for (int i = 0; i < 4; i++) begin
      drive_rec(mk(20 + i)); step();
    end
    in_valid = 1'b0;
    n_cmp++; if (count !== 4'd3 || enable !== 1'b1) begin
      n_err++; $display("FAIL b2b_prefill: got count=%0d en=%b want count=3 en=1", count, enable);
    end
    rs_busy = '0;
    for (int i = 4; i < 24; i++) begin
      drive_rec(mk(20 + i)); step();
      n_cmp++; if (count !== 4'd3) begin n_err++; $display("FAIL b2b_count[%0d]: got %0d want 3", i, count); end
    end
    in_valid = 1'b0;
    repeat (6) step();
    n_cmp++; if (issued.size() !== 24) begin n_err++; $display("FAIL b2b_issue_count: got %0d want 24", issued.size()); end
    for (int k = 0; k < 24; k++) begin
      got = (k < issued.size()) ? issued[k] : 'x;
      n_cmp++; if (got !== mk(20 + k)) begin n_err++; $display("FAIL b2b_order[%0d]: got %h want %h", k, got, mk(20 + k)); end
    end
  endtask

  task automatic test_illegal_imm();
    rec_t ill_r, mv_r;
    ill_r = {3'b110, RS'(1), RS'(1), RS'(1), 1'b0, WS'(0)};
    mv_r  = {3'b100, RS'(9), RS'(10), RS'(11), 1'b1, WS'(-5)};
    issued.delete();
    rs_busy = '0;
    drive_rec(ill_r); step();
    in_valid = 1'b0;
    n_cmp++; if (illegal !== 1'b1) begin n_err++; $display("FAIL illegal_pulse: got %b want 1", illegal); end
    n_cmp++; if (count !== '0) begin n_err++; $display("FAIL illegal_count: got %0d want 0", count); end
    n_cmp++; if (enable !== 1'b0) begin n_err++; $display("FAIL illegal_enable: got %b want 0", enable); end
    step();
    n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL illegal_fall: got %b want 0", illegal); end
    n_cmp++; if (enable !== 1'b0 || count !== '0) begin
      n_err++; $display("FAIL illegal_not_stored: got en=%b count=%0d want 0 0", enable, count);
    end
    drive_rec(mv_r); step();
    in_valid = 1'b0;
    repeat (LAT - 1) step();
    n_cmp++; if (enable !== 1'b1 || unit !== 3'b100 || hasimm !== 1'b1) begin
      n_err++; $display("FAIL imm_issue: got en=%b unit=%0d hasimm=%b want 1 4 1", enable, unit, hasimm);
    end
    n_cmp++; if (imm !== 32'hFFFFFFFB) begin n_err++; $display("FAIL imm_value: got %h want fffffffb", imm); end
    step();
    n_cmp++; if (issued.size() !== 1) begin n_err++; $display("FAIL illegal_issue_count: got %0d want 1", issued.size()); end
  endtask

  task automatic test_reset_mid();
    issued.delete();
    rs_busy = 5'b11111;
    for (int i = 0; i < 6; i++) begin
      drive_rec(mk(50 + i)); step();
    end
    in_valid = 1'b0;
    n_cmp++; if (count !== 4'd5 || enable !== 1'b1) begin
      n_err++; $display("FAIL rstmid_pre: got count=%0d en=%b want count=5 en=1", count, enable);
    end
    rst = 1'b1;
    rs_busy = '0;
    drive_rec(mk(60));
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    n_cmp++; if (count !== '0) begin n_err++; $display("FAIL rstmid_count: got %0d want 0", count); end
    n_cmp++; if (enable !== 1'b0) begin n_err++; $display("FAIL rstmid_enable: got %b want 0", enable); end
    n_cmp++; if ({unit, reg1, reg2, reg3, hasimm, imm} !== rec_t'(0)) begin
      n_err++; $display("FAIL rstmid_fields: got %h want 0", {unit, reg1, reg2, reg3, hasimm, imm});
    end
    repeat (5) step();
    n_cmp++; if (enable !== 1'b0 || count !== '0) begin
      n_err++; $display("FAIL rstmid_after: got en=%b count=%0d want 0 0", enable, count);
    end
    n_cmp++; if (issued.size() !== 0) begin n_err++; $display("FAIL rstmid_issued: got %0d want 0", issued.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stall();
    test_back_to_back();
    test_illegal_imm();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
